// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sizing and bit-reversal helper
package fft_pkg;
  localparam int N = 32;
  localparam int LOGN = 5;
  localparam int DW = 19;
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_pingpong_bank.sv
// fft_pingpong_bank: two-bank register file, one write port, one async read port
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int N = fft_pkg::N,
  parameter int LOGN = fft_pkg::LOGN,
  parameter int W = 2 * fft_pkg::DW
) (
  input  logic            clk,
  input  logic            we,
  input  logic            wbank,
  input  logic [LOGN-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic            rbank,
  input  logic [LOGN-1:0] raddr,
  output logic [W-1:0]    rdata
);
  logic [W-1:0] mem [2][N];
  always_ff @(posedge clk) if (we) mem[wbank][waddr] <= wdata;
  assign rdata = mem[rbank][raddr];
endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong buffer turning bit-reversed FFT output into natural order
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int N = fft_pkg::N,
  parameter int LOGN = fft_pkg::LOGN,
  parameter int DW = fft_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [LOGN-1:0]      out_idx,
  output logic                 out_last
);
  logic [LOGN-1:0] wcnt, rcnt;
  logic wsel, rsel;
  logic [1:0] full;
  logic [2*DW-1:0] rdata;
  logic accept, load;
  assign in_ready = !full[wsel];
  assign accept = in_valid && in_ready;
  assign load = !out_valid || out_ready;
  fft_pingpong_bank #(.N(N), .LOGN(LOGN), .W(2*DW)) u_bank (
    .clk,
    .we(accept),
    .wbank(wsel),
    .waddr(bitrev(wcnt)),
    .wdata({in_r, in_i}),
    .rbank(rsel),
    .raddr(rcnt),
    .rdata
  );
  always_ff @(posedge clk)
    if (rst) begin
      wcnt <= '0;
      rcnt <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      full <= '0;
      out_valid <= 1'b0;
      out_r <= '0;
      out_i <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
    end else begin
      if (accept) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LOGN'(N-1)) begin
          full[wsel] <= 1'b1;
          wsel <= !wsel;
        end
      end
      if (load) out_valid <= full[rsel];
      if (load && full[rsel]) begin
        {out_r, out_i} <= rdata;
        out_idx <= rcnt;
        out_last <= rcnt == LOGN'(N-1);
        rcnt <= rcnt + 1'b1;
        if (rcnt == LOGN'(N-1)) begin
          full[rsel] <= 1'b0;
          rsel <= !rsel;
        end
      end
    end
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: directed self-checking bench for fft_reorder_buf
module tb_fft_reorder_buf;
  localparam int N = 32;
  localparam int LOGN = 5;
  localparam int DW = 19;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic signed [DW-1:0] in_r = 0, in_i = 0, out_r, out_i;
  logic [LOGN-1:0] out_idx;
  int vectors = 0, miscompares = 0, acc_cnt = 0, out_cnt = 0, stall_cnt = 0;
  int t, a0, o0, ek, er, ei, h_r, h_i, h_idx, h_last;
  bit watch = 0, held = 0, bp_done = 0;
  int q_k[$], q_r[$], q_i[$];
  logic [31:0] ext = '0;
  always #5 clk = ~clk;
  fft_reorder_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last)
  );
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int brev(input int j);
    int r = 0;
    for (int b = 0; b < LOGN; b++) r |= ((j >> b) & 1) << (LOGN - 1 - b);
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_sample(input int r, input int i);
    int w = 0;
    in_r = DW'(r);
    in_i = DW'(i);
    in_valid = 1;
    while (!in_ready && w < 1000) begin
      tick();
      w++;
    end
    if (w == 1000) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask
  task automatic send_frame(input int f, input bit gap);
    int nr[N], ni[N];
    for (int k = 0; k < N; k++) begin
      nr[k] = ext[k] ? -(1 << 18) : k + f * 64;
      ni[k] = ext[k] ? (1 << 18) - 1 : -(k + f * 64);
      q_k.push_back(k);
      q_r.push_back(nr[k]);
      q_i.push_back(ni[k]);
    end
    for (int j = 0; j < N; j++) begin
      if (gap && $urandom_range(0, 1) == 1) tick();
      send_sample(nr[brev(j)], ni[brev(j)]);
    end
  endtask
  task automatic drain();
    int w = 0;
    while (q_k.size() != 0 && w < 2000) begin
      tick();
      w++;
    end
    check("drain", q_k.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (in_valid && in_ready) acc_cnt++;
      if (watch && !in_ready) stall_cnt++;
      if (held) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_r", out_r, h_r);
        check("hold_i", out_i, h_i);
        check("hold_idx", int'(out_idx), h_idx);
        check("hold_last", int'(out_last), h_last);
      end
      held = out_valid && !out_ready;
      h_r = out_r;
      h_i = out_i;
      h_idx = out_idx;
      h_last = out_last;
      if (out_valid && out_ready) begin
        if (q_k.size() == 0) check("spurious_out", int'(out_idx), -1);
        else begin
          ek = q_k.pop_front();
          er = q_r.pop_front();
          ei = q_i.pop_front();
          check("out_idx", int'(out_idx), ek);
          check("out_last", int'(out_last), int'(ek == N - 1));
          check("out_r", out_r, er);
          check("out_i", out_i, ei);
          out_cnt++;
        end
      end
    end
  end
  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_i", out_i, 0);
    send_frame(0, 0);
    check("first_pre_valid", int'(out_valid), 0);
    tick();
    check("first_valid", int'(out_valid), 1);
    check("first_idx", int'(out_idx), 0);
    drain();
    o0 = out_cnt;
    watch = 1;
    for (int f = 1; f <= 4; f++) send_frame(f, 0);
    watch = 0;
    drain();
    check("stream_stalls", stall_cnt, 0);
    check("stream_outs", out_cnt - o0, 128);
    out_ready = 0;
    a0 = acc_cnt;
    o0 = out_cnt;
    fork
      begin
        for (int f = 5; f <= 7; f++) send_frame(f, 0);
        bp_done = 1;
      end
    join_none
    t = 0;
    while (acc_cnt - a0 < 64 && t < 500) begin
      tick();
      t++;
    end
    repeat (10) tick();
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_accepts", acc_cnt - a0, 64);
    check("bp_outs_held", out_cnt - o0, 0);
    out_ready = 1;
    t = 0;
    while (!bp_done && t < 1000) begin
      tick();
      t++;
    end
    check("bp_done", int'(bp_done), 1);
    drain();
    check("bp_outs", out_cnt - o0, 96);
    ext[0] = 1;
    ext[7] = 1;
    ext[18] = 1;
    ext[31] = 1;
    ext[$urandom_range(1, 30)] = 1;
    send_frame(8, 0);
    drain();
    ext = '0;
    o0 = out_cnt;
    for (int j = 0; j < 17; j++) send_sample(j + 1000, -j);
    rst = 1;
    tick();
    rst = 0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    repeat (40) tick();
    check("midrst_idle", int'(out_valid), 0);
    check("midrst_outs", out_cnt - o0, 0);
    send_frame(9, 0);
    drain();
    send_frame(0, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
